spi_audio_tx: RTL
=================

Name: spi_audio_tx

Overview:
Serial transmitter for 16-bit audio words, running on clk_25mhz. It is the sending end of the team's three-wire audio link (sclk / mosi / active); the receiving end is the comunication block.
- Words enter through a valid/ready port into a small FIFO.
- The block generates sclk itself and shifts each word out MSB first.
- mosi changes only on sclk falling edges, so the receiver samples it on rising edges.
- Words queued back-to-back stream with active held high continuously.

Parameters:
CLK_DIV, 4, sclk half-period in clk_25mhz cycles (sclk = 25 MHz / (2*CLK_DIV)); legal range >= 2.
FIFO_DEPTH, 4, input FIFO entries; power of 2, >= 2.

Ports:
clk_25mhz  in  1  system clock, 25 MHz
reset  in  1  asynchronous, active-high reset
enable  in  1  permits new words to start; the word in flight always completes
s_data  in  16  audio word to transmit
s_valid  in  1  s_data valid
s_ready  out  1  FIFO not full; push occurs when s_valid && s_ready
sclk_out  out  1  serial clock; idles low
mosi_out  out  1  serial data, MSB first
active_out  out  1  frame-enable line to the receiver
busy  out  1  FSM not in IDLE
word_done  out  1  1-cycle pulse on the 16th falling edge of each word
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset values: sclk_out=0, mosi_out=0, active_out=0, busy=0, word_done=0, fifo_level=0, s_ready=1, FIFO emptied, state=IDLE.
- Reset taking effect mid-word aborts the word immediately; the partial word is not resent.
- All serial outputs are registered.
- FSM states:
  - IDLE: sclk_out=0, active_out=0.
  - SHIFT_LO: sclk_out=0, phase of CLK_DIV cycles.
  - SHIFT_HI: sclk_out=1, phase of CLK_DIV cycles.
  - TRAIL: sclk_out=0, active_out=1, phase of CLK_DIV cycles.
- Internal state: half-period counter hcnt (0..CLK_DIV-1), bit counter bcnt (0..15), 16-bit shift register.
- IDLE -> SHIFT_LO when enable && FIFO not empty:
  - pop the head word into the shift register;
  - next cycle (cycle A): active_out=1 and mosi_out = word[15].
- SHIFT_LO -> SHIFT_HI after CLK_DIV cycles. Rising edges occur at A + CLK_DIV + 2*CLK_DIV*k, for k = 0..15.
- SHIFT_HI -> SHIFT_LO after CLK_DIV cycles (falling edge). Bits 1..15 of a word: the shift register shifts left and mosi_out presents the next bit.
- On the 16th falling edge (cycle A + 32*CLK_DIV):
  - word_done pulses for that one cycle.
  - If enable && FIFO not empty: pop, load, present new MSB in the same cycle, bcnt=0, stay in SHIFT_LO; active_out stays high.
  - Otherwise go to TRAIL; mosi_out=0.
- TRAIL -> IDLE after CLK_DIV cycles; active_out=0 from cycle A + 33*CLK_DIV (single word).
- Frame length: one word holds active_out high for exactly 33*CLK_DIV cycles; N back-to-back words hold it high for (32*N + 1)*CLK_DIV cycles.
- FIFO:
  - A push is visible to the FSM the cycle after it occurs.
  - A pop requires the registered not-empty flag.
  - Simultaneous push and pop in the same cycle is legal; fifo_level is unchanged.
  - When full, s_ready=0 and s_valid is ignored.
  - Occupancy never wraps.
- enable deasserted mid-word: the current word completes, TRAIL follows, and queued words are retained. Pushes remain accepted while enable=0.
- word_done and the fifo_level update for the pop occur in the same cycle.

Decomposition:
- Shared package spi_audio_pkg:
  - constant WORD_W=16;
  - typedef enum tx_state_t {IDLE, SHIFT_LO, SHIFT_HI, TRAIL};
  - the receiver adopts WORD_W from this package.
- Sub-module audio_tx_fifo:
  - synchronous FIFO, parameters WIDTH and DEPTH;
  - ports push/pop/full/empty/level;
  - same clock and asynchronous reset as the top.

Test Plan:
- CLK_DIV=4, push 0xA5C3 with enable=1 -> 16 sclk rising edges; mosi sampled at rises reads 1010010111000011; active_out high for 132 cycles; one word_done pulse.
- Push 0x8001, 0x7FFE, 0x1234 back-to-back -> active_out high for 388 cycles with no drop; 48 rising edges; 3 word_done pulses spaced 128 cycles apart.
- enable=0, push 5 words (FIFO_DEPTH=4) -> s_ready=0 after the 4th push, fifo_level=4, 5th word not accepted; raising enable sends exactly 4 words in order.
- Drop enable during bit 7 of the first of 3 queued words -> word completes, then TRAIL, active_out low; fifo_level=2 and both words retained.
- Assert reset during bit 5 -> all outputs 0 and fifo_level=0 in the reset cycle; after release, a fresh word transmits correctly.
- Loopback into the comunication receiver with CLK_DIV=2 and 4 (active tied via active_out) -> receiver audio_out equals each sent word, with one data_ready pulse per word.

Source files
------------

// File: rtl/spi_audio_pkg.sv
// Shared definitions for the three-wire audio link (sclk / mosi / active).
// The transmitter uses them, and the receiving end takes WORD_W from here
// so that both ends agree on the word size.
package spi_audio_pkg;

    localparam int WORD_W = 16;
    localparam int BIT_W  = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        TRAIL
    } tx_state_t;

endpackage

// File: rtl/audio_tx_fifo.sv
// Synchronous input FIFO for the audio transmitter.
// Ports:
//   clk_25mhz, reset : clock and asynchronous active-high reset
//   push, wr_data    : write request and data; ignored when full
//   pop, rd_data     : read request and head-of-queue data (show-ahead)
//   full, empty      : status flags, derived from the registered occupancy
//   level            : current occupancy, 0..DEPTH
module audio_tx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk_25mhz,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk_25mhz) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_audio_tx.sv
// Serial transmitter for 16-bit audio words. Words are queued through a
// valid/ready port and shifted out MSB first on a self-generated sclk.
// mosi only moves on sclk falling edges, so the receiver samples on rising
// edges. Words that are queued back-to-back stream under one active frame.
// Ports:
//   clk_25mhz, reset   : clock and asynchronous active-high reset
//   enable             : allows new words to start; a word in flight always finishes
//   s_data, s_valid    : input word and its valid flag
//   s_ready            : FIFO not full
//   sclk_out, mosi_out : serial clock (idles low) and serial data
//   active_out         : frame-enable line to the receiver
//   busy               : FSM not in IDLE
//   word_done          : one-cycle pulse on the final falling edge of each word
//   fifo_level         : FIFO occupancy
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no frame; sclk low, active low; waits for enable and a word
// SHIFT_LO | sclk low half-period; mosi holds the current bit
// SHIFT_HI | sclk high half-period; the receiver has sampled the bit
// TRAIL    | sclk low, mosi low, active still high for one half-period
module spi_audio_tx
    import spi_audio_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_25mhz,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [WORD_W-1:0]               s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic                            sclk_out,
    output logic                            mosi_out,
    output logic                            active_out,
    output logic                            busy,
    output logic                            word_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int HW = $clog2(CLK_DIV);
    localparam logic [HW-1:0]    HCNT_MAX = HW'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    tx_state_t         state;
    logic [HW-1:0]     hcnt;
    logic [BIT_W-1:0]  bcnt;
    logic [WORD_W-1:0] shreg;

    logic [WORD_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              hcnt_tc;
    logic              last_fall;

    audio_tx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .push      (s_valid),
        .wr_data   (s_data),
        .pop       (fifo_pop),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign s_ready   = !fifo_full;
    assign busy      = (state != IDLE);
    assign hcnt_tc   = (hcnt == '0);
    assign last_fall = (state == SHIFT_HI) && hcnt_tc && (bcnt == LAST_BIT);

    // A word is popped either to open a frame or to chain onto the word
    // finishing this cycle, so the new MSB appears on the same falling edge.
    assign fifo_pop = enable && !fifo_empty && ((state == IDLE) || last_fall);

    // The shift register MSB is the mosi flop; clearing it idles mosi low.
    assign mosi_out = shreg[WORD_W-1];

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hcnt       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            sclk_out   <= 1'b0;
            active_out <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    sclk_out   <= 1'b0;
                    active_out <= 1'b0;
                    if (fifo_pop) begin
                        shreg      <= fifo_rd_data;
                        active_out <= 1'b1;
                        hcnt       <= HCNT_MAX;
                        bcnt       <= '0;
                        state      <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (hcnt_tc) begin
                        sclk_out <= 1'b1;
                        hcnt     <= HCNT_MAX;
                        state    <= SHIFT_HI;
                    end else begin
                        hcnt <= hcnt - HW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (hcnt_tc) begin
                        sclk_out <= 1'b0;
                        hcnt     <= HCNT_MAX;
                        state    <= SHIFT_LO;
                        if (bcnt == LAST_BIT) begin
                            word_done <= 1'b1;
                            if (fifo_pop) begin
                                shreg <= fifo_rd_data;
                                bcnt  <= '0;
                            end else begin
                                shreg <= '0;
                                state <= TRAIL;
                            end
                        end else begin
                            shreg <= {shreg[WORD_W-2:0], 1'b0};
                            bcnt  <= bcnt + BIT_W'(1);
                        end
                    end else begin
                        hcnt <= hcnt - HW'(1);
                    end
                end
                TRAIL: begin
                    if (hcnt_tc) begin
                        active_out <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        hcnt <= hcnt - HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
